quotient_result_fifo: RTL and testbench
=======================================

Name: quotient_result_fifo

Overview:
- Downstream stage of the 16-bit divider; consumes its quotient valid/ready stream.
- Buffers up to DEPTH results and stamps each with a wrapping sequence tag, so a consumer on a slower or stalling path never blocks the divider for more than a bounded time.
- Presents results first-word-fall-through on a registered valid/ready output, with occupancy and a synchronous flush for software recovery.

Parameters:
- DATA_W, 16, width of quotient data; matches the divider output.
- DEPTH, 4, number of entries; power of two, minimum 2.
- TAG_W, 8, width of the sequence tag.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of buffered entries.
- quotient_data  in  DATA_W  result from the divider.
- quotient_valid  in  1  divider result valid.
- quotient_ready  out  1  FIFO can accept a result.
- out_data  out  DATA_W  head-of-queue quotient.
- out_tag  out  TAG_W  sequence tag of the head entry.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: arst sampled high at a clk edge gives the following.
  - Read and write pointers, level, and tag counter all 0.
  - out_valid=0, out_data=0, out_tag=0.
  - quotient_ready=0 during the reset cycle; it goes to 1 on the first cycle after arst deasserts.
  - Reset mid-transfer discards all entries; nothing is replayed.
- Ready generation:
  - quotient_ready = !full && !flush && !arst.
  - full is a registered flag (level==DEPTH); ready has no combinational path from quotient_valid.
- Push:
  - Occurs when quotient_valid && quotient_ready at a clk edge.
  - Writes {tag_cnt, quotient_data} at the write pointer.
  - Write pointer increments modulo DEPTH; tag_cnt increments modulo 2^TAG_W (0xFF wraps to 0x00).
- Pop:
  - Occurs when out_valid && out_ready at a clk edge.
  - Read pointer increments modulo DEPTH.
- Output stage: out_data/out_tag/out_valid are driven from the head entry, registered.
  - Latency: a push into an empty FIFO gives out_valid=1 on the next cycle, never the same cycle.
  - out_data and out_tag hold stable while out_valid && !out_ready.
- Level per edge:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full: no push, since quotient_ready=0; the pop frees a slot and quotient_ready=1 on the next cycle. There is no same-cycle pass-through when full.
  - When level==1: the pop takes the old head; the new entry becomes the head the next cycle, so out_valid stays 1.
  - When empty: only the push is possible, because out_valid=0.
- Flush:
  - When flush=1 at an edge: pointers and level go to 0 and out_valid goes to 0 next cycle.
  - quotient_ready=0 in the flush cycle, so a concurrent push is refused, not lost.
  - tag_cnt is NOT cleared; tags continue monotonically so software can detect the gap.
  - arst has priority over flush.
- Pointers use one extra wrap bit; full and empty are derived from pointer equality plus the wrap bit, and level from the pointer difference.
- Data is stored as-is; no arithmetic is applied to quotient values. A 0xFFFF from a divide by zero is buffered like any other value.

Test Plan:
- Single transfer: reset; push 0x0005 with out_ready=1 -> out_valid=1 one cycle after the push, out_data=0x0005, out_tag=0x00, level returns to 0 after the pop.
- Fill and stall: out_ready=0; push 0x0001..0x0004 -> level=4 and quotient_ready=0; a fifth valid is held, not accepted. Set out_ready=1 -> outputs 0x0001..0x0004 with tags 0..3 in order, then the fifth value with tag 4.
- Full with simultaneous pop: at level=4, assert quotient_valid and out_ready in the same cycle -> exactly one pop, no push; level=3; quotient_ready=1 next cycle; the push then completes.
- Tag wrap: stream 257 results with out_ready=1 -> tags run 0x00..0xFF then 0x00; no data lost or reordered.
- Flush: with 3 entries buffered (tags 0..2), pulse flush while quotient_valid=1 -> quotient_ready=0 that cycle; out_valid=0 and level=0 next cycle; the subsequent push receives tag 3.
- Reset mid-operation: with 2 entries buffered and out_valid=1, assert arst for 1 cycle -> out_valid=0, level=0, tag restarts at 0x00, quotient_ready=1 the cycle after deassertion.

Source files
------------

// File: rtl/quotient_result_fifo.sv
// quotient_result_fifo: tagged FWFT buffer for divider quotients with registered valid/ready output
module quotient_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        quotient_data,
  input  logic                     quotient_valid,
  output logic                     quotient_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [TAG_W+DATA_W-1:0] mem [DEPTH];
  logic [TAG_W+DATA_W-1:0] head_n;
  logic [PW-1:0] rd, wr, rd_n, wr_n, lvl_n;
  logic [TAG_W-1:0] tag_cnt;
  logic full, push, pop;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
  assign level = wr - rd;
  assign quotient_ready = !full && !flush && !arst;
  assign push = quotient_valid && quotient_ready;
  assign pop = out_valid && out_ready;
  // The next head bypasses the array when it is the entry being written this edge
  always_comb begin
    rd_n = rd + PW'(pop);
    wr_n = wr + PW'(push);
    lvl_n = wr_n - rd_n;
    head_n = (push && rd_n == wr) ? {tag_cnt, quotient_data} : mem[rd_n[AW-1:0]];
  end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= {tag_cnt, quotient_data};
  always_ff @(posedge clk) begin
    if (arst) begin
      rd <= '0;
      wr <= '0;
      tag_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_tag <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      out_valid <= 1'b0;
    end else begin
      rd <= rd_n;
      wr <= wr_n;
      if (push) tag_cnt <= tag_cnt + 1'b1;
      out_valid <= lvl_n != '0;
      {out_tag, out_data} <= head_n;
    end
  end
endmodule

// File: tb/tb_quotient_result_fifo.sv
// tb_quotient_result_fifo: directed vector table, tag-wrap stream and randomized run against a queue model
module tb_quotient_result_fifo;
  logic clk = 1'b0, arst, flush, quotient_valid, quotient_ready, out_valid, out_ready;
  logic [15:0] quotient_data, out_data;
  logic [7:0] out_tag;
  logic [2:0] level;
  int checks = 0, errors = 0;
  logic [23:0] q[$];
  int mtag = 0;

  quotient_result_fifo #(.DATA_W(16), .DEPTH(4), .TAG_W(8)) dut (
    .clk(clk), .arst(arst), .flush(flush), .quotient_data(quotient_data),
    .quotient_valid(quotient_valid), .quotient_ready(quotient_ready),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .level(level));

  always #5 clk = ~clk;

  typedef struct {
    logic a, f, v;
    logic [15:0] d;
    logic r, er, ev;
    logic [15:0] ed;
    logic [7:0] et;
    logic [2:0] el;
  } vec_t;
  vec_t tbl[29];

  function automatic vec_t mk(logic a, f, v, logic [15:0] d, logic r, er, ev,
                              logic [15:0] ed, logic [7:0] et, logic [2:0] el);
    vec_t t;
    t.a = a; t.f = f; t.v = v; t.d = d; t.r = r;
    t.er = er; t.ev = ev; t.ed = ed; t.et = et; t.el = el;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check outputs after
  task automatic step(input logic a, f, v, input logic [15:0] d, input logic r, output logic rdy);
    logic m_ready;
    arst = a; flush = f; quotient_valid = v; quotient_data = d; out_ready = r;
    #1;
    rdy = quotient_ready;
    m_ready = !a && !f && q.size() < 4;
    chk("model_ready", quotient_ready, m_ready);
    @(posedge clk);
    if (a) begin
      q.delete();
      mtag = 0;
    end else if (f) q.delete();
    else begin
      if (r && q.size() > 0) void'(q.pop_front());
      if (v && m_ready) begin
        q.push_back({mtag[7:0], d});
        mtag = (mtag + 1) % 256;
      end
    end
    #1;
    chk("model_valid", out_valid, q.size() != 0);
    chk("model_level", level, q.size());
    if (q.size() != 0) begin
      chk("model_tag", out_tag, q[0][23:16]);
      chk("model_data", out_data, q[0][15:0]);
    end
  endtask

  initial begin
    logic rs;
    int npop;
    tbl[0]  = mk(1,0,0,16'h0000,0, 0,0,16'h0000,8'h00,0);
    tbl[1]  = mk(0,0,0,16'h0000,1, 1,0,16'h0000,8'h00,0);
    tbl[2]  = mk(0,0,1,16'h0005,1, 1,1,16'h0005,8'h00,1);
    tbl[3]  = mk(0,0,0,16'h0000,1, 1,0,16'h0000,8'h00,0);
    tbl[4]  = mk(1,0,0,16'h0000,0, 0,0,16'h0000,8'h00,0);
    tbl[5]  = mk(0,0,1,16'h0001,0, 1,1,16'h0001,8'h00,1);
    tbl[6]  = mk(0,0,1,16'h0002,0, 1,1,16'h0001,8'h00,2);
    tbl[7]  = mk(0,0,1,16'h0003,0, 1,1,16'h0001,8'h00,3);
    tbl[8]  = mk(0,0,1,16'h0004,0, 1,1,16'h0001,8'h00,4);
    tbl[9]  = mk(0,0,1,16'h0005,0, 0,1,16'h0001,8'h00,4);
    tbl[10] = mk(0,0,1,16'h0005,1, 0,1,16'h0002,8'h01,3);
    tbl[11] = mk(0,0,1,16'h0005,0, 1,1,16'h0002,8'h01,4);
    tbl[12] = mk(0,0,0,16'h0000,1, 0,1,16'h0003,8'h02,3);
    tbl[13] = mk(0,0,0,16'h0000,1, 1,1,16'h0004,8'h03,2);
    tbl[14] = mk(0,0,0,16'h0000,1, 1,1,16'h0005,8'h04,1);
    tbl[15] = mk(0,0,0,16'h0000,1, 1,0,16'h0000,8'h00,0);
    tbl[16] = mk(1,0,0,16'h0000,0, 0,0,16'h0000,8'h00,0);
    tbl[17] = mk(0,0,1,16'h0010,0, 1,1,16'h0010,8'h00,1);
    tbl[18] = mk(0,0,1,16'h0011,0, 1,1,16'h0010,8'h00,2);
    tbl[19] = mk(0,0,1,16'h0012,0, 1,1,16'h0010,8'h00,3);
    tbl[20] = mk(0,1,1,16'h0013,0, 0,0,16'h0000,8'h00,0);
    tbl[21] = mk(0,0,1,16'h0013,0, 1,1,16'h0013,8'h03,1);
    tbl[22] = mk(0,0,1,16'h0014,0, 1,1,16'h0013,8'h03,2);
    tbl[23] = mk(1,0,1,16'h0015,0, 0,0,16'h0000,8'h00,0);
    tbl[24] = mk(0,0,1,16'h0015,0, 1,1,16'h0015,8'h00,1);
    tbl[25] = mk(0,0,1,16'h0016,1, 1,1,16'h0016,8'h01,1);
    tbl[26] = mk(0,0,0,16'h0000,1, 1,0,16'h0000,8'h00,0);
    tbl[27] = mk(0,0,1,16'hFFFF,0, 1,1,16'hFFFF,8'h02,1);
    tbl[28] = mk(0,0,0,16'h0000,1, 1,0,16'h0000,8'h00,0);
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].a, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r, rs);
      chk($sformatf("tbl%0d_ready", i), rs, tbl[i].er);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].el);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_tag", i), out_tag, tbl[i].et);
      end
      if (i == 0) begin
        chk("reset_data", out_data, 16'h0000);
        chk("reset_tag", out_tag, 8'h00);
      end
    end
    step(1, 0, 0, 16'h0, 0, rs);
    npop = 0;
    for (int i = 0; i < 261; i++) begin
      if (out_valid) begin
        chk("wrap_tag", out_tag, npop % 256);
        chk("wrap_data", out_data, npop);
        npop++;
      end
      step(0, 0, i < 257, 16'(i), 1, rs);
    end
    chk("wrap_count", npop, 257);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0, ($urandom % 4) != 0,
           16'($urandom), ($urandom % 3) != 0, rs);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
